// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access; data has priority.
// Define ARB_FAIR_EN to bound fetch starvation to MAX_D_STREAK consecutive data grants.
module unified_mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  if_command,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic [1:0]  d_command,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [1:0]  mem_command,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    if (MAX_D_STREAK < 1) begin : g_bad_cfg
        $error("MAX_D_STREAK must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_if_req;
    logic        w_d_req;
    logic        w_fair_force;
    logic        w_pick_if;
    logic        w_grant_if;
    logic        w_grant_d;
    logic [1:0]  r_mem_command;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_if_done;
    logic        r_d_done;

    assign w_if_req  = (if_command != CMD_NONE);
    assign w_d_req   = (d_command == CMD_LOAD) || (d_command == CMD_STORE);
    assign w_pick_if = w_if_req && (!w_d_req || w_fair_force);

`ifdef ARB_FAIR_EN
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] r_streak;

    assign w_fair_force = (r_streak == STREAK_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_grant_if || (r_state == IDLE && !w_if_req)) begin
            r_streak <= '0;
        end else if (w_grant_d && w_if_req) begin
            r_streak <= r_streak + 1'b1;
        end
    end
`else
    assign w_fair_force = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_if) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = GNT_IF;
                end else if (w_d_req) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = GNT_D;
                end
            end
            GNT_IF, GNT_D: begin
                if (mem_ack) w_state_nxt = RESP;
            end
            // No arbitration here: the served requester still shows its stale command.
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mem_command <= CMD_NONE;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_if_done     <= 1'b0;
            r_d_done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            if (w_grant_if) begin
                r_mem_command <= CMD_LOAD;
                r_mem_addr    <= if_addr;
                r_mem_wdata   <= '0;
            end else if (w_grant_d) begin
                r_mem_command <= d_command;
                r_mem_addr    <= d_addr;
                r_mem_wdata   <= d_wdata;
            end
            if (r_state == GNT_IF && mem_ack) begin
                r_mem_command <= CMD_NONE;
                r_if_rdata    <= mem_rdata;
                r_if_done     <= 1'b1;
            end
            if (r_state == GNT_D && mem_ack) begin
                r_mem_command <= CMD_NONE;
                if (r_mem_command == CMD_LOAD) r_d_rdata <= mem_rdata;
                r_d_done      <= 1'b1;
            end
        end
    end

    assign mem_command = r_mem_command;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign if_done     = r_if_done;
    assign d_done      = r_d_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed vector bench for unified_mem_arbiter plus a fairness grant-order sequence.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  if_command;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic [1:0]  d_command;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [1:0]  mem_command;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.MAX_D_STREAK(2)) dut (
        .clk(clk), .rst(rst),
        .if_command(if_command), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_command(d_command), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .mem_command(mem_command), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  ifc;
        logic [31:0] ifa;
        logic [1:0]  dc;
        logic [31:0] da;
        logic [31:0] dw;
        logic        ack;
        logic [31:0] rd;
        logic [1:0]  mc;
        logic [31:0] ma;
        logic [31:0] mw;
        logic        cb;
        logic        ifd;
        logic        dd;
        logic [31:0] ifr;
        logic [31:0] dr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [1:0] ifc, logic [31:0] ifa, logic [1:0] dc,
                                logic [31:0] da, logic [31:0] dw, logic ack, logic [31:0] rd,
                                logic [1:0] mc, logic [31:0] ma, logic [31:0] mw, logic cb,
                                logic ifd, logic dd, logic [31:0] ifr, logic [31:0] dr);
        vec_t v;
        v.rst = r; v.ifc = ifc; v.ifa = ifa; v.dc = dc; v.da = da; v.dw = dw;
        v.ack = ack; v.rd = rd; v.mc = mc; v.ma = ma; v.mw = mw; v.cb = cb;
        v.ifd = ifd; v.dd = dd; v.ifr = ifr; v.dr = dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; if_command = v.ifc; if_addr = v.ifa;
        d_command = v.dc; d_addr = v.da; d_wdata = v.dw;
        mem_ack = v.ack; mem_rdata = v.rd;
    endtask

    logic [31:0] DB, BF, A5;
    bit   exp_if[6];
    bit   got_if[6];
    int   ngr;
    logic [1:0] prev_cmd;

    initial begin
        DB = 32'hDEADBEEF; BF = 32'h0BADF00D; A5 = 32'hA5A5A5A5;
        rst = 1'b1; if_command = '0; if_addr = '0; d_command = '0; d_addr = '0;
        d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        //            rst ifc ifa        dc da         dw     ack rd             mc ma         mw    cb ifd dd ifr dr
        vq.push_back(mk(1, 0, 0,         0, 0,         0,     0, 0,             0, 0,         0,    1, 0, 0, 0,  0));
        vq.push_back(mk(0, 1, 32'h100,   0, 0,         0,     0, 0,             1, 32'h100,   0,    1, 0, 0, 0,  0));
        vq.push_back(mk(0, 1, 32'h100,   0, 0,         0,     1, DB,            0, 0,         0,    0, 1, 0, DB, 0));
        vq.push_back(mk(0, 1, 32'h100,   0, 0,         0,     0, 0,             0, 0,         0,    0, 0, 0, DB, 0));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0, 0, 0,     2, 32'h200,   32'h55, 0, 0,            2, 32'h200,   32'h55, 1, 0, 0, DB, 0));
        vq.push_back(mk(0, 0, 0,         2, 32'h200,   32'h55, 1, 32'h12345678, 0, 0,         0,    0, 0, 1, DB, 0));
        vq.push_back(mk(0, 0, 0,         2, 32'h200,   32'h55, 1, 32'hFFFF0000, 0, 0,         0,    0, 0, 0, DB, 0));
        vq.push_back(mk(0, 0, 0,         0, 0,         0,     1, 32'hFFFF0001,  0, 0,         0,    0, 0, 0, DB, 0));
        vq.push_back(mk(0, 1, 32'h300,   1, 32'h400,   0,     0, 0,             1, 32'h400,   0,    1, 0, 0, DB, 0));
        vq.push_back(mk(0, 1, 32'h300,   1, 32'h400,   0,     1, A5,            0, 0,         0,    0, 0, 1, DB, A5));
        vq.push_back(mk(0, 1, 32'h300,   1, 32'h400,   0,     0, 0,             0, 0,         0,    0, 0, 0, DB, A5));
        vq.push_back(mk(0, 1, 32'h300,   0, 0,         0,     0, 0,             1, 32'h300,   0,    1, 0, 0, DB, A5));
        vq.push_back(mk(0, 1, 32'h300,   0, 0,         0,     1, BF,            0, 0,         0,    0, 1, 0, BF, A5));
        vq.push_back(mk(0, 1, 32'h300,   0, 0,         0,     0, 0,             0, 0,         0,    0, 0, 0, BF, A5));
        vq.push_back(mk(0, 0, 0,         1, 32'h500,   0,     0, 0,             1, 32'h500,   0,    1, 0, 0, BF, A5));
        vq.push_back(mk(0, 0, 0,         0, 0,         0,     0, 0,             1, 32'h500,   0,    1, 0, 0, BF, A5));
        vq.push_back(mk(0, 0, 0,         0, 0,         0,     1, 32'h77,        0, 0,         0,    0, 0, 1, BF, 32'h77));
        vq.push_back(mk(0, 0, 0,         0, 0,         0,     0, 0,             0, 0,         0,    0, 0, 0, BF, 32'h77));
        vq.push_back(mk(0, 1, 32'h600,   0, 0,         0,     0, 0,             1, 32'h600,   0,    1, 0, 0, BF, 32'h77));
        vq.push_back(mk(1, 1, 32'h600,   0, 0,         0,     0, 0,             0, 0,         0,    1, 0, 0, 0,  0));
        vq.push_back(mk(0, 0, 0,         0, 0,         0,     1, 32'hFFFFFFFF,  0, 0,         0,    1, 0, 0, 0,  0));
        vq.push_back(mk(0, 0, 0,         0, 0,         0,     0, 0,             0, 0,         0,    1, 0, 0, 0,  0));
        vq.push_back(mk(0, 0, 0,         3, 32'h900,   32'h9, 0, 0,             0, 0,         0,    1, 0, 0, 0,  0));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mem_command", i), 32'(mem_command), 32'(vq[i].mc));
            if (vq[i].cb) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].ma);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].mw);
            end
            chk($sformatf("v%0d if_done", i), 32'(if_done), 32'(vq[i].ifd));
            chk($sformatf("v%0d d_done", i), 32'(d_done), 32'(vq[i].dd));
            chk($sformatf("v%0d if_rdata", i), if_rdata, vq[i].ifr);
            chk($sformatf("v%0d d_rdata", i), d_rdata, vq[i].dr);
        end

        // Fairness: both requesters held pending, memory acks the cycle after each issue.
`ifdef ARB_FAIR_EN
        exp_if = '{0, 0, 1, 0, 0, 1};
`else
        exp_if = '{0, 0, 0, 0, 0, 0};
`endif
        @(negedge clk);
        rst = 1'b1; if_command = '0; d_command = '0; mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        if_command = 2'd1; if_addr = 32'h800;
        d_command = 2'd1; d_addr = 32'h700; d_wdata = '0;
        prev_cmd = 2'd0;
        ngr = 0;
        for (int cyc = 0; cyc < 60 && ngr < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_ack   = (mem_command != 2'd0);
            mem_rdata = 32'hC0DE0000 + 32'(cyc);
            @(posedge clk);
            #1;
            if (prev_cmd == 2'd0 && mem_command != 2'd0) begin
                got_if[ngr] = (mem_addr == 32'h800);
                ngr++;
            end
            prev_cmd = mem_command;
            if (if_done && d_done) chk("both_done", 32'd1, 32'd0);
        end
        chk("fair_grant_count", 32'(ngr), 32'd6);
        for (int g = 0; g < 6; g++)
            if (g < ngr) chk($sformatf("fair_grant%0d_is_fetch", g), 32'(got_if[g]), 32'(exp_if[g]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
